spi_fword_loader: RTL and testbench
===================================

// Module: spi_fword_loader
// PURPOSE
//  Frames the SPI slave's received byte stream into 32-bit DDS frequency words and feeds dds_addr.FWORD.
//  Checks each frame and commits the word atomically, so the phase accumulator never sees a half-written word.
//  rxd_flag and cs arrive from the clk_30M domain; this block synchronises them into clk.
// PARAMETERS
//  DEFAULT_FWORD  32'hC5B0_5B05  fword_out value after reset and after a CMD_DEFAULT frame
//  TIMEOUT_CYC    27_000         max clk cycles between bytes inside a frame (1 ms @ 27 MHz)
//  TO_W           15             timeout counter width; 2**TO_W must be > TIMEOUT_CYC
// PORTS
//  clk           in   1   DDS/system clock; sole clock of this block
//  rst           in   1   asynchronous, active-low reset
//  rxd_data      in   8   received byte from spi_slaver; held stable until the next byte
//  rxd_flag      in   1   byte-received strobe, clk_30M domain (asynchronous here)
//  cs            in   1   SPI chip select, active-low, asynchronous
//  fword_out     out  32  committed frequency word to dds_addr.FWORD
//  fword_update  out  1   1-cycle pulse in the cycle fword_out changes
//  status_byte   out  8   {ok,err_chk,err_to,err_abort,busy,cnt_sat,2'b00}; drives the spi_slaver reply data
// BEHAVIOUR
//  Reset (async, rst=0):
//   fword_out=DEFAULT_FWORD, fword_update=0, status_byte=8'h00; FSM=IDLE; shadow register, XOR accumulator
//   and timeout counter cleared.
//  Input sync:
//   rxd_flag and cs each pass through 2 FFs. byte_stb = rising edge of synced rxd_flag.
//   rxd_data is sampled in the byte_stb cycle. Byte-accept latency is 3 clk after the rxd_flag rise.
//   cs_rise = synced cs 0->1 (deselect).
//  Frame formats:
//   CMD_SET:     8'hA5, B3, B2, B1, B0, CHK. Data is MSB first. CHK = A5^B3^B2^B1^B0.
//   CMD_DEFAULT: 8'h5A, CHK. CHK = 8'h5A.
//  FSM:
//   IDLE: byte_stb with A5 -> DATA, idx=0, xacc=A5.
//         byte_stb with 5A -> CHK, dflt=1, xacc=5A.
//         Any other byte is ignored and sets no flag.
//   DATA: each byte_stb shifts the byte into shadow[31:0] MSB first and XORs it into xacc.
//         The 4th byte (idx==3) moves the FSM to CHK.
//   CHK:  on byte_stb, if byte==xacc, the next cycle sets fword_out=shadow (or DEFAULT_FWORD when dflt),
//         pulses fword_update and sets ok=1, err_chk=0. On mismatch it sets err_chk=1, ok=0 and leaves
//         fword_out unchanged. Either way the FSM returns to IDLE.
//  Timeout:
//   Counter clears on every byte_stb and counts in DATA/CHK.
//   Reaching TIMEOUT_CYC -> IDLE, err_to=1, no commit. The counter saturates and never wraps.
//  Abort:
//   cs_rise while in DATA/CHK -> IDLE, err_abort=1, no commit. cs_rise in IDLE has no effect.
//  Simultaneous events:
//   cs_rise and byte_stb in the same cycle: the byte is processed first (this can complete a commit),
//   then the abort is applied only if the FSM is still in DATA/CHK.
//   Timeout and byte_stb in the same cycle: the byte wins.
//  Status flags:
//   busy = FSM!=IDLE.
//   Error flags are sticky until the next successful commit, which clears err_chk, err_to and err_abort.
//   cnt_sat = 1 once 255 commits have occurred (internal 8-bit commit counter, saturating).
//  Reset mid-frame drops the frame; fword_out returns to DEFAULT_FWORD immediately.
//  fword_out changes only in fword_update cycles. dds_addr must never see a partial word.
// STRUCTURE
//  Shared include fword_pkg.vh:
//   CMD_SET=8'hA5, CMD_DEFAULT=8'h5A, FSM state encodings S_IDLE/S_DATA/S_CHK, status bit indices.
//  Sub-module sync_edge (2-FF synchroniser + rising-edge detector, async active-low reset) is
//  instantiated twice, for rxd_flag and cs.
//  Everything else (FSM, shadow register, XOR accumulator, timeout, status) lives in spi_fword_loader.
// TESTING
//  1 Send A5 12 34 56 78 AD -> fword_out=32'h12345678; fword_update high exactly 1 cycle,
//    4 clk after the CHK rxd_flag rise; status_byte=8'h80.
//  2 Send A5 12 34 56 78 00 -> fword_out unchanged, no fword_update pulse, status_byte=8'h40.
//  3 After test 1, send 5A 5A -> fword_out=32'hC5B0_5B05 with one fword_update pulse.
//  4 Send A5 12 34, then stall for TIMEOUT_CYC cycles -> FSM=IDLE, err_to=1, fword_out unchanged.
//    A following valid frame commits and clears err_to.
//  5 Send A5 12, then raise cs -> err_abort=1, no commit.
//    Send 33 then A5 11 22 33 44 CHK -> 33 ignored, fword_out=32'h11223344.
//  6 Pull rst low in DATA after 2 bytes -> fword_out=DEFAULT_FWORD, status_byte=8'h00 asynchronously.
//    Once rst is released, a fresh frame commits correctly.

Source files
------------

// File: rtl/spi_fword_loader_pkg.sv
// Shared constants and types for the SPI frequency-word loader.
package spi_fword_loader_pkg;

  localparam logic [7:0] CMD_SET     = 8'hA5;
  localparam logic [7:0] CMD_DEFAULT = 8'h5A;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DATA = 2'd1;
  localparam logic [1:0] S_CHK  = 2'd2;

  // Bit order matches the reply byte seen by the SPI master.
  typedef struct packed {
    logic       ok;
    logic       err_chk;
    logic       err_to;
    logic       err_abort;
    logic       busy;
    logic       cnt_sat;
    logic [1:0] rsvd;
  } status_t;

endpackage

// File: rtl/spi_fword_loader_sync_edge.sv
// Two-flop synchroniser followed by a rising-edge detector on the synced level.
module spi_fword_loader_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic [2:0] sh;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sh <= 3'b000;
    else      sh <= {sh[1:0], d};
  end

  assign rise = sh[1] & ~sh[2];

endmodule

// File: rtl/spi_fword_loader.sv
// Frames SPI bytes into 32-bit DDS frequency words, checks the XOR checksum
// and commits the word in a single cycle.
//
// state  | meaning
// S_IDLE | waiting for a command byte
// S_DATA | collecting the four frequency-word bytes, MSB first
// S_CHK  | waiting for the checksum byte
module spi_fword_loader
  import spi_fword_loader_pkg::*;
#(
  parameter logic [31:0] DEFAULT_FWORD = 32'hC5B0_5B05,
  parameter int          TIMEOUT_CYC   = 27_000,
  parameter int          TO_W          = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rxd_data,
  input  logic        rxd_flag,
  input  logic        cs,
  output logic [31:0] fword_out,
  output logic        fword_update,
  output logic [7:0]  status_byte
);

  logic            byte_stb, cs_rise;
  logic [1:0]      state, state_nxt;
  logic [1:0]      idx, idx_nxt;
  logic [7:0]      xacc, xacc_nxt;
  logic [31:0]     shadow, shadow_nxt;
  logic            dflt, dflt_nxt;
  logic            pend_nxt, pend_q;
  logic [31:0]     commit_word;
  logic            set_err_chk, set_to, set_abort;
  logic [TO_W-1:0] to_cnt;
  logic            to_hit;
  logic [7:0]      commit_cnt;
  logic            ok, err_chk, err_to, err_abort;
  status_t         sts;

  spi_fword_loader_sync_edge u_sync_flag (
    .clk  (clk),
    .rst  (rst),
    .d    (rxd_flag),
    .rise (byte_stb)
  );

  spi_fword_loader_sync_edge u_sync_cs (
    .clk  (clk),
    .rst  (rst),
    .d    (cs),
    .rise (cs_rise)
  );

  assign to_hit = (to_cnt == TO_W'(TIMEOUT_CYC));

  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    xacc_nxt    = xacc;
    shadow_nxt  = shadow;
    dflt_nxt    = dflt;
    pend_nxt    = 1'b0;
    set_err_chk = 1'b0;
    set_to      = 1'b0;
    set_abort   = 1'b0;
    case (state)
      S_IDLE: begin
        if (byte_stb) begin
          if (rxd_data == CMD_SET) begin
            state_nxt = S_DATA;
            idx_nxt   = 2'd0;
            xacc_nxt  = CMD_SET;
            dflt_nxt  = 1'b0;
          end else if (rxd_data == CMD_DEFAULT) begin
            state_nxt = S_CHK;
            xacc_nxt  = CMD_DEFAULT;
            dflt_nxt  = 1'b1;
          end
        end
      end
      S_DATA: begin
        if (byte_stb) begin
          shadow_nxt = {shadow[23:0], rxd_data};
          xacc_nxt   = xacc ^ rxd_data;
          idx_nxt    = idx + 2'd1;
          if (idx == 2'd3) state_nxt = S_CHK;
        end else if (to_hit) begin
          state_nxt = S_IDLE;
          set_to    = 1'b1;
        end
      end
      S_CHK: begin
        if (byte_stb) begin
          state_nxt = S_IDLE;
          if (rxd_data == xacc) pend_nxt = 1'b1;
          else                  set_err_chk = 1'b1;
        end else if (to_hit) begin
          state_nxt = S_IDLE;
          set_to    = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    // The byte is consumed before a deselect is allowed to abort the frame.
    if (cs_rise && state_nxt != S_IDLE) begin
      state_nxt = S_IDLE;
      set_abort = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      idx         <= 2'd0;
      xacc        <= 8'h00;
      shadow      <= 32'h0;
      dflt        <= 1'b0;
      pend_q      <= 1'b0;
      commit_word <= 32'h0;
      to_cnt      <= '0;
    end else begin
      state  <= state_nxt;
      idx    <= idx_nxt;
      xacc   <= xacc_nxt;
      shadow <= shadow_nxt;
      dflt   <= dflt_nxt;
      pend_q <= pend_nxt;
      if (pend_nxt) commit_word <= dflt ? DEFAULT_FWORD : shadow;
      if (byte_stb || state == S_IDLE) to_cnt <= '0;
      else if (!to_hit)                to_cnt <= to_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fword_out    <= DEFAULT_FWORD;
      fword_update <= 1'b0;
      commit_cnt   <= 8'h00;
      ok           <= 1'b0;
      err_chk      <= 1'b0;
      err_to       <= 1'b0;
      err_abort    <= 1'b0;
    end else begin
      fword_update <= pend_q;
      if (pend_q) begin
        fword_out <= commit_word;
        ok        <= 1'b1;
        err_chk   <= 1'b0;
        err_to    <= 1'b0;
        err_abort <= 1'b0;
        if (commit_cnt != 8'hFF) commit_cnt <= commit_cnt + 8'd1;
      end
      if (set_err_chk) begin
        err_chk <= 1'b1;
        ok      <= 1'b0;
      end
      if (set_to)    err_to    <= 1'b1;
      if (set_abort) err_abort <= 1'b1;
    end
  end

  always_comb begin
    sts           = '0;
    sts.ok        = ok;
    sts.err_chk   = err_chk;
    sts.err_to    = err_to;
    sts.err_abort = err_abort;
    sts.busy      = (state != S_IDLE);
    sts.cnt_sat   = (commit_cnt == 8'hFF);
  end

  assign status_byte = sts;

endmodule

// File: tb/tb_spi_fword_loader.sv
// Directed bench for spi_fword_loader: framing, checksum, timeout, abort, reset and commit saturation.
module tb_spi_fword_loader;

  localparam int TIMEOUT_CYC = 27_000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  rxd_data = 8'h00;
  logic        rxd_flag = 1'b0;
  logic        cs = 1'b0;
  logic [31:0] fword_out;
  logic        fword_update;
  logic [7:0]  status_byte;

  int n_chk = 0, n_fail = 0;
  int cyc = 0, rise_cyc = 0, upd_cyc = 0, upd_cnt = 0, viol = 0, commits = 0, upd0;
  logic [31:0] prev_fw = 32'hC5B0_5B05;

  spi_fword_loader dut (
    .clk          (clk),
    .rst          (rst),
    .rxd_data     (rxd_data),
    .rxd_flag     (rxd_flag),
    .cs           (cs),
    .fword_out    (fword_out),
    .fword_update (fword_update),
    .status_byte  (status_byte)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (fword_update) begin
      upd_cnt = upd_cnt + 1;
      upd_cyc = cyc;
    end
    if (rst && fword_out !== prev_fw && !fword_update) viol = viol + 1;
    prev_fw = fword_out;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (obs !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit raise_cs = 1'b0);
    @(negedge clk);
    rxd_data = b;
    rxd_flag = 1'b1;
    if (raise_cs) cs = 1'b1;
    rise_cyc = cyc;
    repeat (4) @(negedge clk);
    rxd_flag = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_val("reset_fword", fword_out, 32'hC5B0_5B05);
    check_val("reset_status", {24'h0, status_byte}, 32'h00);
    check_val("reset_update", {31'h0, fword_update}, 32'h0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // valid set frame
    upd0 = upd_cnt;
    send_byte(8'hA5);
    check_val("t1_busy", {24'h0, status_byte}, 32'h08);
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
    send_byte(8'hAD);
    check_val("t1_fword", fword_out, 32'h1234_5678);
    check_val("t1_upd_pulses", upd_cnt - upd0, 1);
    check_val("t1_upd_latency", upd_cyc - rise_cyc, 4);
    check_val("t1_status", {24'h0, status_byte}, 32'h80);
    commits++;

    // bad checksum
    upd0 = upd_cnt;
    send_byte(8'hA5); send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
    send_byte(8'h00);
    check_val("t2_fword", fword_out, 32'h1234_5678);
    check_val("t2_upd_pulses", upd_cnt - upd0, 0);
    check_val("t2_status", {24'h0, status_byte}, 32'h40);

    // default frame
    upd0 = upd_cnt;
    send_byte(8'h5A); send_byte(8'h5A);
    check_val("t3_fword", fword_out, 32'hC5B0_5B05);
    check_val("t3_upd_pulses", upd_cnt - upd0, 1);
    check_val("t3_status", {24'h0, status_byte}, 32'h80);
    commits++;

    // timeout after A5 12 34
    send_byte(8'hA5); send_byte(8'h12); send_byte(8'h34);
    repeat (TIMEOUT_CYC - 30) @(negedge clk);
    check_val("t4_busy_before_to", {31'h0, status_byte[3]}, 32'h1);
    repeat (50) @(negedge clk);
    check_val("t4_busy_after_to", {31'h0, status_byte[3]}, 32'h0);
    check_val("t4_err_to", {31'h0, status_byte[5]}, 32'h1);
    check_val("t4_fword", fword_out, 32'hC5B0_5B05);
    send_byte(8'hA5); send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
    send_byte(8'h87);
    check_val("t4_recover_fword", fword_out, 32'hDEAD_BEEF);
    check_val("t4_recover_status", {24'h0, status_byte}, 32'h80);
    commits++;

    // abort via cs, then garbage byte and valid frame
    upd0 = upd_cnt;
    send_byte(8'hA5); send_byte(8'h12);
    @(negedge clk); cs = 1'b1;
    repeat (6) @(negedge clk);
    check_val("t5_abort_status", {24'h0, status_byte}, 32'h90);
    check_val("t5_abort_upd", upd_cnt - upd0, 0);
    cs = 1'b0;
    repeat (4) @(negedge clk);
    send_byte(8'h33);
    check_val("t5_ignored_status", {24'h0, status_byte}, 32'h90);
    send_byte(8'hA5); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    send_byte(8'hE1);
    check_val("t5_fword", fword_out, 32'h1122_3344);
    check_val("t5_status", {24'h0, status_byte}, 32'h80);
    commits++;

    // asynchronous reset mid-frame
    send_byte(8'hA5); send_byte(8'h12); send_byte(8'h34);
    check_val("t6_busy", {24'h0, status_byte}, 32'h88);
    @(negedge clk); #2;
    rst = 1'b0;
    #1;
    check_val("t6_rst_fword", fword_out, 32'hC5B0_5B05);
    check_val("t6_rst_status", {24'h0, status_byte}, 32'h00);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    commits = 0;
    repeat (2) @(negedge clk);
    send_byte(8'hA5); send_byte(8'hCA); send_byte(8'hFE); send_byte(8'hBA); send_byte(8'hBE);
    send_byte(8'h95);
    check_val("t6_fword", fword_out, 32'hCAFE_BABE);
    check_val("t6_status", {24'h0, status_byte}, 32'h80);
    commits++;

    // checksum byte and deselect arrive together: commit wins, no abort
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    send_byte(8'hA1, 1'b1);
    check_val("sim_fword", fword_out, 32'h0102_0304);
    check_val("sim_status", {24'h0, status_byte}, 32'h80);
    cs = 1'b0;
    repeat (4) @(negedge clk);
    commits++;

    // commit counter saturation
    while (commits < 254) begin
      send_byte(8'h5A); send_byte(8'h5A);
      commits++;
    end
    check_val("sat_254", {24'h0, status_byte}, 32'h80);
    send_byte(8'h5A); send_byte(8'h5A);
    check_val("sat_255", {24'h0, status_byte}, 32'h84);
    send_byte(8'h5A); send_byte(8'h5A);
    check_val("sat_256", {24'h0, status_byte}, 32'h84);

    check_val("fword_only_on_update", viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
